mc_ctrl_param: RTL

Parametrised multicycle control FSM for the byte-fetch MIPS datapath. It is the successor to the fixed four-beat controller, with these additions:
- Configurable instruction fetch beat count.
- A memory-ready wait handshake on every memory state.
- A sticky memory-timeout error.
- An illegal-opcode pulse.

It sits beside the datapath and drives its mux selects and write enables from the opcode and the ALU zero flag.

---
 rtl/mc_ctrl_pkg.sv | 72 +++++++
 rtl/mc_wait_timer.sv | 62 ++++++
 rtl/mc_ctrl_param.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// ============================================================================
// Module      : mc_ctrl_pkg
// Description : Shared types and encodings for the parametrised multicycle
//               MIPS controller (state enum, opcodes, mux encodings).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_LBRD    = 4'd3,
    S_LBWR    = 4'd4,
    S_SBWR    = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWR = 4'd7,
    S_BEQEX   = 4'd8,
    S_JEX     = 4'd9,
    S_ADDIWR  = 4'd10,
    S_BNEEX   = 4'd11
  } state_t;

  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ALUSRCB_REG    = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR   = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM    = 2'b10;
  localparam logic [1:0] ALUSRCB_BRANCH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Raw control word before reset gating; pcen is derived from the pcwrite fields.
  typedef struct packed {
    logic       memread;
    logic       memwrite;
    logic       alusrca;
    logic       memtoreg;
    logic       iord;
    logic       regwrite;
    logic       regdst;
    logic       pcwrite;
    logic       pcwritecond;
    logic       pcen_inv;
    logic       irwrite_en;
    logic       illegal_op;
    logic [1:0] pcsource;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
  } ctl_t;

  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_LBRD) || (s == S_SBWR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mc_wait_timer.sv
// ============================================================================
// Module      : mc_wait_timer
// Description : Counts memory stall cycles in a wait state and raises a
//               sticky err once the count reaches TIMEOUT (0 = disabled).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_wait_timer #(
  parameter int TIMEOUT = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic in_wait,
  input  logic mem_ready,
  input  logic state_change,
  output logic err
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             stall;
  logic             hit;

  assign stall = in_wait & ~mem_ready & ~state_change;

  // err is raised on the edge that completes the TIMEOUT-th stalled cycle.
  generate
    if (TIMEOUT > 0) begin : g_timeout_on
      assign hit = stall && (cnt_q == CNT_W'(TIMEOUT - 1));
    end else begin : g_timeout_off
      assign hit = 1'b0;
    end
  endgenerate

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q | hit;
    if (!stall) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_W'(TIMEOUT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;

endmodule

`default_nettype wire

// File: rtl/mc_ctrl_param.sv
// ============================================================================
// Module      : mc_ctrl_param
// Description : Parametrised multicycle control FSM for the byte-fetch MIPS
//               datapath. Optional BNE support via macro MC_CTRL_BNE_EN.
//               FETCH_BEATS must be 1, 2 or 4.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_ctrl_param
  import mc_ctrl_pkg::*;
#(
  parameter int FETCH_BEATS = 4,
  parameter int TIMEOUT     = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [5:0]             op,
  input  logic                   zero,
  input  logic                   mem_ready,
  output logic                   memread,
  output logic                   memwrite,
  output logic                   alusrca,
  output logic                   memtoreg,
  output logic                   iord,
  output logic                   pcen,
  output logic                   regwrite,
  output logic                   regdst,
  output logic [1:0]             pcsource,
  output logic [1:0]             alusrcb,
  output logic [1:0]             aluop,
  output logic [FETCH_BEATS-1:0] irwrite,
  output logic                   illegal_op,
  output logic                   err
);

`ifdef MC_CTRL_BNE_EN
  localparam bit BNE_EN = 1'b1;
`else
  localparam bit BNE_EN = 1'b0;
`endif

  localparam int              BEAT_W    = (FETCH_BEATS > 1) ? $clog2(FETCH_BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FETCH_BEATS - 1);

  state_t            state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  ctl_t              ctl;
  ctl_t              ctl_g;
  logic              in_wait;
  logic              state_change;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    ctl     = '0;
    state_d = state_q;
    beat_d  = beat_q;
    case (state_q)
      S_FETCH: begin
        ctl.memread  = 1'b1;
        ctl.alusrcb  = ALUSRCB_FOUR;
        ctl.pcsource = PCSRC_ALU;
        if (mem_ready) begin
          ctl.irwrite_en = 1'b1;
          ctl.pcwrite    = 1'b1;
          if (beat_q == LAST_BEAT) begin
            state_d = S_DECODE;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      S_DECODE: begin
        ctl.alusrcb = ALUSRCB_BRANCH;
        ctl.aluop   = ALUOP_ADD;
        case (op)
          OP_LB, OP_SB, OP_ADDI: state_d = S_MEMADR;
          OP_RTYPE:              state_d = S_RTYPEEX;
          OP_BEQ:                state_d = S_BEQEX;
          OP_J:                  state_d = S_JEX;
          OP_BNE: begin
            if (BNE_EN) begin
              state_d = S_BNEEX;
            end else begin
              ctl.illegal_op = 1'b1;
              state_d        = S_FETCH;
            end
          end
          default: begin
            ctl.illegal_op = 1'b1;
            state_d        = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ctl.alusrca = 1'b1;
        ctl.alusrcb = ALUSRCB_IMM;
        case (op)
          OP_LB:   state_d = S_LBRD;
          OP_SB:   state_d = S_SBWR;
          OP_ADDI: state_d = S_ADDIWR;
          default: state_d = S_FETCH;
        endcase
      end
      S_LBRD: begin
        ctl.memread = 1'b1;
        ctl.iord    = 1'b1;
        if (mem_ready) state_d = S_LBWR;
      end
      S_LBWR: begin
        ctl.regwrite = 1'b1;
        ctl.memtoreg = 1'b1;
        state_d      = S_FETCH;
      end
      S_SBWR: begin
        ctl.memwrite = 1'b1;
        ctl.iord     = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_RTYPEEX: begin
        ctl.alusrca = 1'b1;
        ctl.aluop   = ALUOP_FUNCT;
        state_d     = S_RTYPEWR;
      end
      S_RTYPEWR: begin
        ctl.regdst   = 1'b1;
        ctl.regwrite = 1'b1;
        state_d      = S_FETCH;
      end
      S_BEQEX: begin
        ctl.alusrca     = 1'b1;
        ctl.aluop       = ALUOP_SUB;
        ctl.pcsource    = PCSRC_ALUOUT;
        ctl.pcwritecond = 1'b1;
        state_d         = S_FETCH;
      end
      S_BNEEX: begin
        if (BNE_EN) begin
          ctl.alusrca     = 1'b1;
          ctl.aluop       = ALUOP_SUB;
          ctl.pcsource    = PCSRC_ALUOUT;
          ctl.pcwritecond = 1'b1;
          ctl.pcen_inv    = 1'b1;
        end
        state_d = S_FETCH;
      end
      S_JEX: begin
        ctl.pcwrite  = 1'b1;
        ctl.pcsource = PCSRC_JUMP;
        state_d      = S_FETCH;
      end
      S_ADDIWR: begin
        ctl.regwrite = 1'b1;
        state_d      = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Outputs are held low for the whole reset assertion, not just after an edge.
  assign ctl_g = reset ? '0 : ctl;

  assign memread    = ctl_g.memread;
  assign memwrite   = ctl_g.memwrite;
  assign alusrca    = ctl_g.alusrca;
  assign memtoreg   = ctl_g.memtoreg;
  assign iord       = ctl_g.iord;
  assign regwrite   = ctl_g.regwrite;
  assign regdst     = ctl_g.regdst;
  assign pcsource   = ctl_g.pcsource;
  assign alusrcb    = ctl_g.alusrcb;
  assign aluop      = ctl_g.aluop;
  assign illegal_op = ctl_g.illegal_op;
  assign pcen       = ctl_g.pcwrite | (ctl_g.pcwritecond & (zero ^ ctl_g.pcen_inv));

  // Byte lanes fill MSB first: beat 0 writes lane FETCH_BEATS-1.
  generate
    for (genvar i = 0; i < FETCH_BEATS; i++) begin : g_irwrite
      assign irwrite[i] = ctl_g.irwrite_en && (beat_q == BEAT_W'(FETCH_BEATS - 1 - i));
    end
  endgenerate

  assign in_wait      = is_wait_state(state_q);
  assign state_change = (state_d != state_q);

  mc_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clk         (clk),
    .reset       (reset),
    .in_wait     (in_wait),
    .mem_ready   (mem_ready),
    .state_change(state_change),
    .err         (err)
  );

endmodule

`default_nettype wire
